// File: rtl/rdma_rx_hdr_extract.sv
// RDMA RX header extractor: strips the fixed RDMA header from an AXI-Stream packet,
// latches decoded fields and forwards the payload through a 2-entry skid buffer.
// Optional build macro: RX_HDR_MAGIC_CHECK_EN (word6[31:8] must equal 24'hABABAB).
module rdma_rx_hdr_extract #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned HDR_WORDS  = 7,
   parameter bit          LEN_CHECK  = 1'b1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [7:0]            rdma_opcode,
   output logic [23:0]           rdma_psn,
   output logic [23:0]           rdma_dest_qp,
   output logic [63:0]           rdma_remote_addr,
   output logic [15:0]           fragment_offset,
   output logic [31:0]           rdma_length,
   output logic [15:0]           rdma_partition_key,
   output logic [7:0]            rdma_service_level,
   output logic                  header_valid,
   output logic                  parsing_busy,
   output logic                  err_short,
   output logic                  err_len,
   output logic                  err_magic
);

   localparam int unsigned HDR_BEATS = (HDR_WORDS * 32 + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int unsigned BCW       = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(HDR_BEATS - 1);
   localparam int unsigned SKW       = DATA_WIDTH + KEEP_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_t;

   state_t                        state_q, state_d;
   logic [BCW-1:0]                beat_cnt_q, beat_cnt_d, idx;
   logic [HDR_BEATS*DATA_WIDTH-1:0] hdr_q, hdr_d;
   logic [31:0]                   byte_cnt_q, byte_cnt_d;
   logic [32:0]                   byte_sum;
   logic                          hv_q, hv_d, es_q, es_d, el_q, el_d;
   logic                          len_pend_q, len_pend_d, fld_upd, s_ready, acc, push, pop;
   logic [SKW-1:0]                buf0_q, buf1_q, s_beat;
   logic [1:0]                    skid_cnt_q;
   logic [7:0]                    opcode_q, sl_q;
   logic [23:0]                   psn_q, qp_q;
   logic [31:0]                   addr_q, len_q;
   logic [15:0]                   frag_q, pkey_q;

   function automatic int unsigned popcnt(input logic [KEEP_WIDTH-1:0] k);
      int unsigned r = 0;
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) r = r + 32'(k[i]);
      return r;
   endfunction

   assign s_ready  = (state_q == S_FWD) ? (skid_cnt_q != 2'd2) : 1'b1;
   assign acc      = s_axis_tvalid & s_ready;
   assign pop      = (skid_cnt_q != 2'd0) & m_axis_tready;
   assign s_beat   = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   assign byte_sum = {1'b0, byte_cnt_q} + 33'(popcnt(s_axis_tkeep));

`ifdef RX_HDR_MAGIC_CHECK_EN
   logic em_q, em_d;
`endif

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      hdr_d      = hdr_q;
      byte_cnt_d = byte_cnt_q;
      hv_d       = 1'b0;
      es_d       = 1'b0;
      el_d       = len_pend_q;
      len_pend_d = 1'b0;
      fld_upd    = 1'b0;
      push       = 1'b0;
      idx        = '0;
`ifdef RX_HDR_MAGIC_CHECK_EN
      em_d       = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_HDR: begin
            if (acc) begin
               idx = (state_q == S_IDLE) ? '0 : beat_cnt_q;
               hdr_d[idx*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
               if (idx == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  byte_cnt_d = '0;
`ifdef RX_HDR_MAGIC_CHECK_EN
                  if (hdr_d[223:200] != 24'hABABAB) begin
                     em_d    = 1'b1;
                     state_d = s_axis_tlast ? S_IDLE : S_DROP;
                  end else
`endif
                  begin
                     hv_d       = 1'b1;
                     fld_upd    = 1'b1;
                     // header-only length error is deferred one cycle to keep it apart from header_valid
                     len_pend_d = LEN_CHECK & s_axis_tlast & (hdr_d[159:128] != 32'd0);
                     state_d    = s_axis_tlast ? S_IDLE : S_FWD;
                  end
               end else if (s_axis_tlast) begin
                  es_d       = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = S_IDLE;
               end else begin
                  beat_cnt_d = idx + BCW'(1);
                  state_d    = S_HDR;
               end
            end
         end
         S_FWD: begin
            if (acc) begin
               push       = 1'b1;
               byte_cnt_d = byte_sum[32] ? '1 : byte_sum[31:0];
               if (s_axis_tlast) begin
                  el_d    = len_pend_q | (LEN_CHECK & (byte_cnt_d != len_q));
                  state_d = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (acc && s_axis_tlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         hdr_q      <= '0;
         byte_cnt_q <= '0;
         hv_q       <= 1'b0;
         es_q       <= 1'b0;
         el_q       <= 1'b0;
         len_pend_q <= 1'b0;
         opcode_q   <= '0;
         psn_q      <= '0;
         qp_q       <= '0;
         addr_q     <= '0;
         frag_q     <= '0;
         len_q      <= '0;
         pkey_q     <= '0;
         sl_q       <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         hdr_q      <= hdr_d;
         byte_cnt_q <= byte_cnt_d;
         hv_q       <= hv_d;
         es_q       <= es_d;
         el_q       <= el_d;
         len_pend_q <= len_pend_d;
         if (fld_upd) begin
            opcode_q <= hdr_d[7:0];
            psn_q    <= hdr_d[31:8];
            qp_q     <= hdr_d[55:32];
            addr_q   <= hdr_d[95:64];
            frag_q   <= hdr_d[111:96];
            len_q    <= hdr_d[159:128];
            pkey_q   <= hdr_d[175:160];
            sl_q     <= hdr_d[199:192];
         end
      end
   end

`ifdef RX_HDR_MAGIC_CHECK_EN
   always_ff @(posedge aclk) begin
      if (areset) em_q <= 1'b0;
      else        em_q <= em_d;
   end
   assign err_magic = em_q;
`else
   assign err_magic = 1'b0;
`endif

   // Skid buffer: buf0 is the head and drives m_axis directly.
   always_ff @(posedge aclk) begin
      if (areset) begin
         skid_cnt_q <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (skid_cnt_q == 2'd0) buf0_q <= s_beat;
               else                    buf1_q <= s_beat;
               skid_cnt_q <= skid_cnt_q + 2'd1;
            end
            2'b01: begin
               buf0_q     <= buf1_q;
               skid_cnt_q <= skid_cnt_q - 2'd1;
            end
            2'b11: begin
               if (skid_cnt_q == 2'd1) buf0_q <= s_beat;
               else begin
                  buf0_q <= buf1_q;
                  buf1_q <= s_beat;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_axis_tready      = s_ready & ~areset;
   assign m_axis_tvalid      = (skid_cnt_q != 2'd0);
   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = buf0_q;
   assign parsing_busy       = (state_q != S_IDLE);
   assign header_valid       = hv_q;
   assign err_short          = es_q;
   assign err_len            = el_q;
   assign rdma_opcode        = opcode_q;
   assign rdma_psn           = psn_q;
   assign rdma_dest_qp       = qp_q;
   assign rdma_remote_addr   = {32'd0, addr_q};
   assign fragment_offset    = frag_q;
   assign rdma_length        = len_q;
   assign rdma_partition_key = pkey_q;
   assign rdma_service_level = sl_q;

endmodule

// File: tb/tb_rdma_rx_hdr_extract.sv
// Scoreboard bench for rdma_rx_hdr_extract: a 32-bit and a 64-bit instance share clock and reset.
module tb_rdma_rx_hdr_extract;

   typedef struct packed {
      logic [7:0]  opc;
      logic [23:0] psn;
      logic [23:0] qp;
      logic [31:0] addr;
      logic [15:0] frag;
      logic [31:0] len;
      logic [15:0] pkey;
      logic [7:0]  sl;
      logic [23:0] magic;
   } hdr_t;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic aclk = 1'b0, areset = 1'b1;
   always #5 aclk = ~aclk;

   logic [31:0] s32_tdata = '0, m32_tdata;
   logic [3:0]  s32_tkeep = '0, m32_tkeep;
   logic s32_tvalid = 1'b0, s32_tlast = 1'b0, s32_tready;
   logic m32_tvalid, m32_tlast, m32_tready = 1'b1;
   logic [7:0]  opc32, sl32;
   logic [23:0] psn32, qp32;
   logic [63:0] addr32;
   logic [15:0] frag32, pkey32;
   logic [31:0] len32;
   logic hv32, busy32, es32, el32, em32;

   logic [63:0] s64_tdata = '0, m64_tdata;
   logic [7:0]  s64_tkeep = '0, m64_tkeep;
   logic s64_tvalid = 1'b0, s64_tlast = 1'b0, s64_tready;
   logic m64_tvalid, m64_tlast, m64_tready = 1'b1;
   logic [7:0]  opc64, sl64;
   logic [23:0] psn64, qp64;
   logic [63:0] addr64;
   logic [15:0] frag64, pkey64;
   logic [31:0] len64;
   logic hv64, busy64, es64, el64, em64;

   rdma_rx_hdr_extract #(.DATA_WIDTH(32)) dut32 (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s32_tdata), .s_axis_tkeep(s32_tkeep), .s_axis_tvalid(s32_tvalid),
      .s_axis_tready(s32_tready), .s_axis_tlast(s32_tlast),
      .m_axis_tdata(m32_tdata), .m_axis_tkeep(m32_tkeep), .m_axis_tvalid(m32_tvalid),
      .m_axis_tready(m32_tready), .m_axis_tlast(m32_tlast),
      .rdma_opcode(opc32), .rdma_psn(psn32), .rdma_dest_qp(qp32), .rdma_remote_addr(addr32),
      .fragment_offset(frag32), .rdma_length(len32), .rdma_partition_key(pkey32),
      .rdma_service_level(sl32), .header_valid(hv32), .parsing_busy(busy32),
      .err_short(es32), .err_len(el32), .err_magic(em32));

   rdma_rx_hdr_extract #(.DATA_WIDTH(64)) dut64 (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s64_tdata), .s_axis_tkeep(s64_tkeep), .s_axis_tvalid(s64_tvalid),
      .s_axis_tready(s64_tready), .s_axis_tlast(s64_tlast),
      .m_axis_tdata(m64_tdata), .m_axis_tkeep(m64_tkeep), .m_axis_tvalid(m64_tvalid),
      .m_axis_tready(m64_tready), .m_axis_tlast(m64_tlast),
      .rdma_opcode(opc64), .rdma_psn(psn64), .rdma_dest_qp(qp64), .rdma_remote_addr(addr64),
      .fragment_offset(frag64), .rdma_length(len64), .rdma_partition_key(pkey64),
      .rdma_service_level(sl64), .header_valid(hv64), .parsing_busy(busy64),
      .err_short(es64), .err_len(el64), .err_magic(em64));

   int n_checks = 0, n_fail = 0;
   int hv32_cnt = 0, es32_cnt = 0, el32_cnt = 0, em32_cnt = 0, hv64_cnt = 0, el64_cnt = 0;
   bit tog32 = 1'b0;
   beat_t pay32_q[$], pay64_q[$];
   hdr_t  hdr32_q[$], hdr64_q[$];
   beat_t b32, b64;
   hdr_t  h32e, h64e;

   function automatic logic [31:0] hword(input hdr_t h, input int k);
      case (k)
         0: return {h.psn, h.opc};
         1: return {8'h00, h.qp};
         2: return h.addr;
         3: return {16'h0000, h.frag};
         4: return h.len;
         5: return {16'h0000, h.pkey};
         6: return {h.magic, h.sl};
         default: return 32'h0;
      endcase
   endfunction

   // Output monitors: pop expected beats/headers as the DUTs present them.
   always @(negedge aclk) begin
      if (!areset) begin
         if (m32_tvalid && m32_tready) begin
            n_checks++;
            if (pay32_q.size() == 0) begin
               n_fail++;
               $display("FAIL pay32_extra: got beat %h, required none", m32_tdata);
            end else begin
               b32 = pay32_q.pop_front();
               if ({m32_tdata, m32_tkeep, m32_tlast} !== {b32.d[31:0], b32.k[3:0], b32.l}) begin
                  n_fail++;
                  $display("FAIL pay32: got %h/%h/%b, required %h/%h/%b", m32_tdata, m32_tkeep,
                           m32_tlast, b32.d[31:0], b32.k[3:0], b32.l);
               end
            end
         end
         if (hv32) begin
            hv32_cnt++;
            n_checks++;
            if (hdr32_q.size() == 0 || es32 || el32 || em32) begin
               n_fail++;
               $display("FAIL hv32_unexpected: got hv with errs %b%b%b, queue %0d", es32, el32, em32,
                        hdr32_q.size());
            end else begin
               h32e = hdr32_q.pop_front();
               if ({opc32, psn32, qp32, addr32, frag32, len32, pkey32, sl32} !==
                   {h32e.opc, h32e.psn, h32e.qp, 32'd0, h32e.addr, h32e.frag, h32e.len, h32e.pkey, h32e.sl}) begin
                  n_fail++;
                  $display("FAIL fields32: got op %h psn %h len %h sl %h, required op %h psn %h len %h sl %h",
                           opc32, psn32, len32, sl32, h32e.opc, h32e.psn, h32e.len, h32e.sl);
               end
            end
         end
         if (es32) es32_cnt++;
         if (el32) el32_cnt++;
         if (em32) em32_cnt++;
         if (m64_tvalid && m64_tready) begin
            n_checks++;
            if (pay64_q.size() == 0) begin
               n_fail++;
               $display("FAIL pay64_extra: got beat %h, required none", m64_tdata);
            end else begin
               b64 = pay64_q.pop_front();
               if ({m64_tdata, m64_tkeep, m64_tlast} !== {b64.d, b64.k, b64.l}) begin
                  n_fail++;
                  $display("FAIL pay64: got %h/%h/%b, required %h/%h/%b", m64_tdata, m64_tkeep,
                           m64_tlast, b64.d, b64.k, b64.l);
               end
            end
         end
         if (hv64) begin
            hv64_cnt++;
            n_checks++;
            if (hdr64_q.size() == 0) begin
               n_fail++;
               $display("FAIL hv64_unexpected: got header_valid, required none");
            end else begin
               h64e = hdr64_q.pop_front();
               if ({opc64, psn64, qp64, addr64, frag64, len64, pkey64, sl64} !==
                   {h64e.opc, h64e.psn, h64e.qp, 32'd0, h64e.addr, h64e.frag, h64e.len, h64e.pkey, h64e.sl}) begin
                  n_fail++;
                  $display("FAIL fields64: got op %h len %h, required op %h len %h", opc64, len64,
                           h64e.opc, h64e.len);
               end
            end
         end
         if (el64) el64_cnt++;
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
      if (tog32) m32_tready = ~m32_tready;
   endtask

   task automatic send_beat32(input logic [31:0] d, input logic [3:0] k, input logic l, output bit ok);
      bit rdy;
      s32_tdata = d; s32_tkeep = k; s32_tlast = l; s32_tvalid = 1'b1; ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         rdy = s32_tready;
         tick();
         if (rdy) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL accept32_timeout: got tready low 200 cycles, required acceptance");
      end
   endtask

   task automatic send_beat64(input logic [63:0] d, input logic [7:0] k, input logic l);
      bit rdy, ok;
      s64_tdata = d; s64_tkeep = k; s64_tlast = l; s64_tvalid = 1'b1; ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         rdy = s64_tready;
         tick();
         if (rdy) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL accept64_timeout: got tready low 200 cycles, required acceptance");
      end
   endtask

   task automatic send_pkt32(input hdr_t h, input int npay, input logic [3:0] lastk,
                             input int short_at, input bit exp_hv, input bit chk_lat);
      bit ok;
      logic [31:0] d;
      logic [3:0] k;
      logic l;
      for (int i = 0; i < 7; i++) begin
         l = (i == short_at) || (i == 6 && npay == 0);
         if (i == 6 && exp_hv) hdr32_q.push_back(h);
         send_beat32(hword(h, i), 4'hF, l, ok);
         if (i == short_at) begin
            n_checks++;
            if (es32 !== 1'b1 || hv32 !== 1'b0) begin
               n_fail++;
               $display("FAIL short_pulse: got err_short %b hv %b, required 1 0", es32, hv32);
            end
            s32_tvalid = 1'b0;
            return;
         end
         if (i == 6) begin
            n_checks++;
            if (hv32 !== exp_hv) begin
               n_fail++;
               $display("FAIL hv_timing: got header_valid %b, required %b", hv32, exp_hv);
            end
         end
      end
      for (int p = 0; p < npay; p++) begin
         k = (p == npay - 1) ? lastk : 4'hF;
         l = (p == npay - 1);
         d = $urandom;
         if (exp_hv) pay32_q.push_back('{d: {32'd0, d}, k: {4'd0, k}, l: l});
         send_beat32(d, k, l, ok);
         if (chk_lat) begin
            n_checks++;
            if (m32_tvalid !== 1'b1 || m32_tdata !== d) begin
               n_fail++;
               $display("FAIL latency: got valid %b data %h, required 1 %h", m32_tvalid, m32_tdata, d);
            end
         end
      end
      s32_tvalid = 1'b0;
   endtask

   task automatic send_pkt64(input hdr_t h, input int npay, input logic [7:0] lastk);
      logic [63:0] d;
      logic [7:0] k;
      for (int j = 0; j < 4; j++) begin
         if (j == 3) hdr64_q.push_back(h);
         send_beat64({hword(h, 2*j+1), hword(h, 2*j)}, 8'hFF, 1'b0);
      end
      n_checks++;
      if (hv64 !== 1'b1) begin
         n_fail++;
         $display("FAIL hv64_timing: got %b, required 1", hv64);
      end
      for (int p = 0; p < npay; p++) begin
         k = (p == npay - 1) ? lastk : 8'hFF;
         d = {$urandom, $urandom};
         pay64_q.push_back('{d: d, k: k, l: (p == npay - 1)});
         send_beat64(d, k, (p == npay - 1));
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 100 && (pay32_q.size() != 0 || m32_tvalid || pay64_q.size() != 0); c++) tick();
      tick(); tick();
      n_checks++;
      if (pay32_q.size() != 0 || pay64_q.size() != 0 || hdr32_q.size() != 0 || hdr64_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got pending pay32 %0d pay64 %0d hdr32 %0d hdr64 %0d, required 0",
                  pay32_q.size(), pay64_q.size(), hdr32_q.size(), hdr64_q.size());
      end
   endtask

   task automatic check_zero(input string tag);
      n_checks++;
      if ({s32_tready, m32_tvalid, m32_tdata, m32_tkeep, m32_tlast, opc32, psn32, qp32, addr32, frag32,
           len32, pkey32, sl32, hv32, busy32, es32, el32, em32} !== '0) begin
         n_fail++;
         $display("FAIL %s: got tready %b mvalid %b busy %b op %h len %h, required all 0", tag,
                  s32_tready, m32_tvalid, busy32, opc32, len32);
      end
   endtask

   function automatic hdr_t mk_hdr(input logic [7:0] opc, input logic [23:0] psn, input logic [31:0] len);
      hdr_t h;
      h.opc = opc; h.psn = psn; h.len = len;
      h.qp = 24'h00BEEF ^ 24'(psn); h.addr = 32'hDEAD0000 | 32'(opc); h.frag = 16'h0040;
      h.pkey = 16'hFFFF; h.sl = 8'h03; h.magic = 24'hABABAB;
      return h;
   endfunction

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) tick();
      check_zero("reset_outputs");
      areset = 1'b0;
      tick();
      n_checks++;
      if (s32_tready !== 1'b1 || busy32 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got tready %b busy %b, required 1 0", s32_tready, busy32);
      end
   endtask

   task automatic test_basic();
      int hv0 = hv32_cnt, e0 = es32_cnt + el32_cnt + em32_cnt;
      send_pkt32(mk_hdr(8'h0A, 24'h000123, 32'd16), 4, 4'hF, -1, 1'b1, 1'b1);
      drain();
      n_checks++;
      if (hv32_cnt - hv0 != 1 || es32_cnt + el32_cnt + em32_cnt != e0) begin
         n_fail++;
         $display("FAIL basic_counts: got hv %0d errs %0d, required 1 0", hv32_cnt - hv0,
                  es32_cnt + el32_cnt + em32_cnt - e0);
      end
   endtask

   task automatic test_backpressure();
      int hv0 = hv32_cnt, e0 = es32_cnt + el32_cnt;
      tog32 = 1'b1;
      send_pkt32(mk_hdr(8'h0A, 24'h000123, 32'd24), 6, 4'hF, -1, 1'b1, 1'b0);
      drain();
      tog32 = 1'b0;
      m32_tready = 1'b1;
      n_checks++;
      if (hv32_cnt - hv0 != 1 || es32_cnt + el32_cnt != e0) begin
         n_fail++;
         $display("FAIL bp_counts: got hv %0d errs %0d, required 1 0", hv32_cnt - hv0, es32_cnt + el32_cnt - e0);
      end
   endtask

   task automatic test_short();
      int hv0 = hv32_cnt, es0 = es32_cnt;
      send_pkt32(mk_hdr(8'h11, 24'h000777, 32'd8), 0, 4'hF, 4, 1'b0, 1'b0);
      drain();
      n_checks++;
      if (hv32_cnt != hv0 || es32_cnt - es0 != 1) begin
         n_fail++;
         $display("FAIL short_counts: got hv %0d es %0d, required 0 1", hv32_cnt - hv0, es32_cnt - es0);
      end
      send_pkt32(mk_hdr(8'h12, 24'h000778, 32'd8), 2, 4'hF, -1, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_len_err();
      int el0 = el32_cnt;
      send_pkt32(mk_hdr(8'h21, 24'h000100, 32'd20), 4, 4'hF, -1, 1'b1, 1'b0);
      n_checks++;
      if (el32 !== 1'b1) begin
         n_fail++;
         $display("FAIL len_pulse: got err_len %b, required 1", el32);
      end
      drain();
      send_pkt32(mk_hdr(8'h22, 24'h000101, 32'd15), 4, 4'h7, -1, 1'b1, 1'b0);
      drain();
      n_checks++;
      if (el32_cnt - el0 != 1) begin
         n_fail++;
         $display("FAIL len_counts: got %0d err_len pulses, required 1", el32_cnt - el0);
      end
   endtask

   task automatic test_hdr_only();
      int el0 = el32_cnt;
      send_pkt32(mk_hdr(8'h31, 24'h000200, 32'd8), 0, 4'hF, -1, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (el32 !== 1'b1) begin
         n_fail++;
         $display("FAIL hdr_only_len: got err_len %b, required 1", el32);
      end
      send_pkt32(mk_hdr(8'h32, 24'h000201, 32'd0), 0, 4'hF, -1, 1'b1, 1'b0);
      drain();
      n_checks++;
      if (el32_cnt - el0 != 1) begin
         n_fail++;
         $display("FAIL hdr_only_counts: got %0d err_len pulses, required 1", el32_cnt - el0);
      end
   endtask

   task automatic test_magic();
      hdr_t h = mk_hdr(8'h41, 24'h000300, 32'd12);
      int hv0 = hv32_cnt, em0 = em32_cnt;
      h.magic = 24'h12ABAB; h.sl = 8'h05;
`ifdef RX_HDR_MAGIC_CHECK_EN
      send_pkt32(h, 3, 4'hF, -1, 1'b0, 1'b0);
      drain();
      n_checks++;
      if (em32_cnt - em0 != 1 || hv32_cnt != hv0) begin
         n_fail++;
         $display("FAIL magic: got em %0d hv %0d, required 1 0", em32_cnt - em0, hv32_cnt - hv0);
      end
`else
      send_pkt32(h, 3, 4'hF, -1, 1'b1, 1'b0);
      drain();
      n_checks++;
      if (em32_cnt != em0 || hv32_cnt - hv0 != 1) begin
         n_fail++;
         $display("FAIL magic_ignored: got em %0d hv %0d, required 0 1", em32_cnt - em0, hv32_cnt - hv0);
      end
`endif
   endtask

   task automatic test_reset_mid();
      hdr_t h = mk_hdr(8'h51, 24'h000400, 32'd8);
      bit ok;
      hdr32_q.push_back(h);
      for (int i = 0; i < 7; i++) send_beat32(hword(h, i), 4'hF, 1'b0, ok);
      m32_tready = 1'b0;
      send_beat32(32'hCAFE0001, 4'hF, 1'b0, ok);
      send_beat32(32'hCAFE0002, 4'hF, 1'b0, ok);
      s32_tvalid = 1'b0;
      areset = 1'b1;
      tick();
      check_zero("reset_mid_fwd");
      areset = 1'b0;
      m32_tready = 1'b1;
      pay32_q.delete();
      tick();
      send_pkt32(mk_hdr(8'h52, 24'h000401, 32'd8), 2, 4'hF, -1, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_back_to_back();
      int hv0 = hv64_cnt, el0 = el64_cnt;
      send_pkt64(mk_hdr(8'h61, 24'h000500, 32'd20), 3, 8'h0F);
      send_pkt64(mk_hdr(8'h62, 24'h000501, 32'd16), 2, 8'hFF);
      s64_tvalid = 1'b0;
      drain();
      n_checks++;
      if (hv64_cnt - hv0 != 2 || el64_cnt != el0) begin
         n_fail++;
         $display("FAIL b2b_counts: got hv %0d el %0d, required 2 0", hv64_cnt - hv0, el64_cnt - el0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_short();
      test_len_err();
      test_hdr_only();
      test_magic();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
